// File: rtl/uart_tx_dev_if.sv
// uart_tx_dev_if: Bridge-side register bus for the UART transmitter.
//   Addr  32  byte address (only [3:2] decoded by the device)
//   WE     1  write strobe, already qualified by Bridge decode
//   Din   32  write data
//   Dout  32  read data, combinational from Addr
// master = Bridge/CPU side, slave = device side.
interface uart_tx_dev_if;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;

   modport master (output Addr, output WE, output Din, input Dout);
   modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped UART transmitter with an 8-entry byte FIFO.
// Ports:
//   clk    system clock, all state on posedge
//   reset  asynchronous, active-low
//   bus    uart_tx_dev_if.slave register port (Addr/WE/Din/Dout)
//   IRQ    level interrupt, ie & done
//   tx     serial line, idle high
// Register map (Addr[3:2]): 0 DATA, 1 STATUS, 2 DIV, 3 CTRL.
// Optional feature: define UART_TX_PARITY_EN to add a parity bit after the
// data bits (CTRL[2] selects odd parity).
module uart_tx_dev #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_dev_if.slave   bus,
   output logic           IRQ,
   output logic           tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          state, state_n;
   logic [15:0]     div_q, div_eff, bit_div, bit_cnt;
   logic            en_q, ie_q, odd_q, ovf_q, done_q;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   cnt;
   logic [7:0]      shreg;
   logic [2:0]      bit_idx;
   logic            par_bit;
   logic [31:0]     rdata;

   // register decode
   logic wr_data, wr_status, wr_div, wr_ctrl;
   assign wr_data   = bus.WE && (bus.Addr[3:2] == 2'd0);
   assign wr_status = bus.WE && (bus.Addr[3:2] == 2'd1);
   assign wr_div    = bus.WE && (bus.Addr[3:2] == 2'd2);
   assign wr_ctrl   = bus.WE && (bus.Addr[3:2] == 2'd3);

   logic full, empty, busy, pop, push, bit_end, done_set;
   assign full     = (cnt == CW'(FIFO_DEPTH));
   assign empty    = (cnt == '0);
   assign busy     = (state != S_IDLE);
   assign pop      = (state == S_IDLE) && en_q && !empty;
   // a pop in the same cycle frees a slot, so a push into a full FIFO is kept
   assign push     = wr_data && (!full || pop);
   assign bit_end  = (bit_cnt == 16'd0);
   assign done_set = (state == S_STOP) && bit_end && empty;
   assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q  <= DIV_RESET;
         en_q   <= 1'b0;
         ie_q   <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         if (wr_div) div_q <= bus.Din[15:0];
         if (wr_ctrl) begin
            en_q <= bus.Din[0];
            ie_q <= bus.Din[1];
         end
         if (wr_data && !push) ovf_q <= 1'b1;
         else if (wr_status)   ovf_q <= 1'b0;
         // set wins over a same-cycle clear
         if (done_set)                   done_q <= 1'b1;
         else if (wr_status || wr_data)  done_q <= 1'b0;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       odd_q <= 1'b0;
      else if (wr_ctrl) odd_q <= bus.Din[2];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   par_bit <= 1'b0;
      else if (pop) par_bit <= (^mem[rptr]) ^ odd_q;
   end
`else
   assign odd_q   = 1'b0;
   assign par_bit = 1'b0;
`endif

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.Din[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: ;
         endcase
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (pop) state_n = S_START;
         S_START:  if (bit_end) state_n = S_DATA;
`ifdef UART_TX_PARITY_EN
         S_DATA:   if (bit_end && bit_idx == 3'd7) state_n = S_PARITY;
         S_PARITY: if (bit_end) state_n = S_STOP;
`else
         S_DATA:   if (bit_end && bit_idx == 3'd7) state_n = S_STOP;
`endif
         S_STOP:   if (bit_end) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state)
         S_START:  tx = 1'b0;
         S_DATA:   tx = shreg[0];
         S_PARITY: tx = par_bit;
         default:  tx = 1'b1;
      endcase
   end

   // bit timer and shifter; bit_div is frozen per frame so DIV writes
   // only affect the next frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_div <= 16'd1;
         bit_cnt <= 16'd0;
         shreg   <= 8'd0;
         bit_idx <= 3'd0;
      end else if (pop) begin
         shreg   <= mem[rptr];
         bit_div <= div_eff;
         bit_cnt <= div_eff - 16'd1;
         bit_idx <= 3'd0;
      end else if (busy) begin
         if (bit_end) begin
            bit_cnt <= bit_div - 16'd1;
            if (state == S_DATA) begin
               shreg   <= {1'b0, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            bit_cnt <= bit_cnt - 16'd1;
         end
      end
   end

   // ---------------- read mux / IRQ ----------------
   always_comb begin
      rdata = '0;
      case (bus.Addr[3:2])
         2'd1: begin
            rdata[0]      = busy;
            rdata[1]      = full;
            rdata[2]      = empty;
            rdata[3]      = ovf_q;
            rdata[4]      = done_q;
            rdata[8 +: CW] = cnt;
         end
         2'd2: rdata[15:0] = div_q;
         2'd3: rdata[2:0]  = {odd_q, ie_q, en_q};
         default: rdata = '0;
      endcase
   end

   assign bus.Dout = rdata;
   assign IRQ      = ie_q & done_q;

   logic unused_ok;
   assign unused_ok = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din[31:16]};
endmodule

// File: tb/tb_uart_tx_dev.sv
module tb_uart_tx_dev;
   logic clk = 1'b0;
   logic reset;
   logic irq, tx;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
   localparam logic [31:0] CTRL5_RB = 32'h5;
`else
   localparam int NBITS = 10;
   localparam logic [31:0] CTRL5_RB = 32'h1;
`endif

   uart_tx_dev_if bus();

   uart_tx_dev dut (.clk(clk), .reset(reset), .bus(bus), .IRQ(irq), .tx(tx));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      int         div;
      logic       odd;
   } frame_t;
   frame_t sb_q[$];

   typedef struct {
      logic        we;
      logic [1:0]  a;
      logic [31:0] d;
      logic        sb;
      logic [31:0] exp;
      string       nm;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(logic we, logic [1:0] a, logic [31:0] d,
                               logic sb, logic [31:0] exp, string nm);
      vec_t v;
      v.we = we; v.a = a; v.d = d; v.sb = sb; v.exp = exp; v.nm = nm;
      tbl.push_back(v);
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      bus.Addr = {28'd0, a, 2'b00};
      bus.Din  = d;
      bus.WE   = 1'b1;
      @(posedge clk);
      #1 bus.WE = 1'b0;
   endtask

   task automatic push_byte(logic [7:0] b, int div, logic odd);
      frame_t f;
      f.b = b; f.div = div; f.odd = odd;
      sb_q.push_back(f);
      wr(2'd0, {24'd0, b});
   endtask

   task automatic rd_chk(logic [1:0] a, logic [31:0] exp, string nm);
      bus.Addr = {28'd0, a, 2'b00};
      bus.WE   = 1'b0;
      @(negedge clk);
      chk(nm, bus.Dout, exp);
   endtask

   // wait until every queued frame has gone out and the FIFO is idle
   task automatic wait_drain(string nm);
      int n = 0;
      bus.Addr = 32'h4;
      bus.WE   = 1'b0;
      @(negedge clk);
      while (!(sb_q.size() == 0 && bus.Dout[0] == 1'b0 && bus.Dout[2] == 1'b1) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {31'd0, n < 3000}, 32'd1);
   endtask

   // serial monitor: checks every sample of each frame against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && reset && tx == 1'b0) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_frame: got start bit expected idle line");
               for (int w = 0; w < 2000 && tx == 1'b0; w++) @(negedge clk);
            end else begin
               frame_t      f;
               logic [10:0] seq;
               logic [10:0] got;
               bit          bad;
               f   = sb_q.pop_front();
               bad = 1'b0;
               got = '1;
               seq = '1;
               seq[0]   = 1'b0;
               seq[8:1] = f.b;
`ifdef UART_TX_PARITY_EN
               seq[9]   = (^f.b) ^ f.odd;
`endif
               for (int i = 0; i < NBITS; i++) begin
                  for (int k = 0; k < f.div; k++) begin
                     if (!(i == 0 && k == 0)) @(negedge clk);
                     if (k == 0) got[i] = tx;
                     if (tx !== seq[i]) bad = 1'b1;
                  end
               end
               n_chk++;
               if (bad) begin
                  n_fail++;
                  $display("FAIL frame %02h div %0d: got bits %b expected %b", f.b, f.div, got, seq);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen, early;

      bus.Addr = '0;
      bus.Din  = '0;
      bus.WE   = 1'b0;
      reset    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // ---- table: reset values, register readback, FIFO overflow ----
      add(0, 2'd1, 0, 0, 32'h004, "rst_status");
      add(0, 2'd2, 0, 0, 32'h010, "rst_div");
      add(0, 2'd3, 0, 0, 32'h000, "rst_ctrl");
      add(0, 2'd0, 0, 0, 32'h000, "data_rd");
      add(1, 2'd2, 32'hABCD_0001, 0, 0, "");
      add(0, 2'd2, 0, 0, 32'h001, "div_rb");
      add(1, 2'd3, 32'hFFFF_FFF2, 0, 0, "");
      add(0, 2'd3, 0, 0, 32'h002, "ctrl_rb");
      add(1, 2'd3, 32'h0, 0, 0, "");
      for (int i = 0; i < 9; i++) add(1, 2'd0, 32'h11 + i, i < 8, 0, "");
      add(0, 2'd1, 0, 0, 32'h80A, "ovf_status");
      add(1, 2'd1, 32'h0, 0, 0, "");
      add(0, 2'd1, 0, 0, 32'h802, "ovf_clr");
      add(1, 2'd3, 32'h1, 0, 0, "");

      foreach (tbl[i]) begin
         if (tbl[i].we) begin
            if (tbl[i].a == 2'd0 && tbl[i].sb) push_byte(tbl[i].d[7:0], 1, 1'b0);
            else wr(tbl[i].a, tbl[i].d);
         end else begin
            rd_chk(tbl[i].a, tbl[i].exp, tbl[i].nm);
         end
      end
      wait_drain("drain_ovf");
      rd_chk(2'd1, 32'h014, "done_status");
      chk("irq_ie0", {31'd0, irq}, 32'd0);

      // ---- A: DIV=4, 0xA5, busy length ----
      wr(2'd2, 32'd4);
      wr(2'd3, 32'd1);
      push_byte(8'hA5, 4, 1'b0);
      bus.Addr = 32'h4;
      n = 0; seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (bus.Dout[0]) begin seen = 1'b1; n++; end
         else if (seen) break;
      end
      chk("busy_len", n, NBITS * 4);
      wait_drain("drain_a5");

      // ---- B: two frames at DIV=2 with ie, IRQ at drain, push clears ----
      wr(2'd1, 32'h0);
      rd_chk(2'd1, 32'h004, "done_clr");
      wr(2'd2, 32'd2);
      wr(2'd3, 32'd3);
      push_byte(8'h01, 2, 1'b0);
      push_byte(8'h02, 2, 1'b0);
      bus.Addr = 32'h4;
      early = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(sb_q.size() == 0 && bus.Dout[0] == 1'b0) && n < 500) begin
         if (irq) early = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("irq_early", {31'd0, early}, 32'd0);
      chk("irq_rise", {31'd0, irq}, 32'd1);
      push_byte(8'h03, 2, 1'b0);
      @(negedge clk);
      chk("irq_push_clr", {31'd0, irq}, 32'd0);
      wait_drain("drain_b");
      chk("irq_again", {31'd0, irq}, 32'd1);
      wr(2'd3, 32'd1);
      @(negedge clk);
      chk("irq_ie_off", {31'd0, irq}, 32'd0);

      // ---- C: DIV=0 acts as 1; DIV write mid-frame affects next frame ----
      wr(2'd2, 32'd0);
      rd_chk(2'd2, 32'h0, "div0_rb");
      push_byte(8'h5A, 1, 1'b0);
      @(negedge clk);
      wr(2'd2, 32'd5);
      wait_drain("drain_div1");
      push_byte(8'h3C, 5, 1'b0);
      wait_drain("drain_div5");

      // ---- E: parity select (plain frames when parity is not built) ----
      wr(2'd2, 32'd1);
      push_byte(8'h07, 1, 1'b0);
      wait_drain("drain_even");
      wr(2'd3, 32'd5);
      rd_chk(2'd3, CTRL5_RB, "ctrl_odd_rb");
      push_byte(8'h07, 1, 1'b1);
      wait_drain("drain_odd");

      // ---- D: asynchronous reset in the middle of the data bits ----
      wr(2'd2, 32'd4);
      wr(2'd3, 32'd3);
      mon_en = 1'b0;
      wr(2'd0, 32'h00);
      repeat (8) @(negedge clk);
      chk("tx_pre_rst", {31'd0, tx}, 32'd0);
      #1 reset = 1'b0;
      #1 chk("tx_rst", {31'd0, tx}, 32'd1);
      chk("irq_rst", {31'd0, irq}, 32'd0);
      bus.Addr = 32'h4;
      #1 chk("status_rst", bus.Dout, 32'h004);
      bus.Addr = 32'h8;
      #1 chk("div_rst", bus.Dout, 32'h010);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      rd_chk(2'd1, 32'h004, "post_rst");
      chk("tx_idle", {31'd0, tx}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
